// File: rtl/capture_sequencer.sv
// Run controller for the byte-serial capture path: locks on the frame header, counts
// whole frames, backs off on FIFO full, and supervises the header-search timeout.
module capture_sequencer #(
    parameter int unsigned NFRAME_WIDTH  = 10,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned FRAME_BYTES   = 48,
    parameter logic [7:0]  HEADER        = 8'hBC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic                     cmd_abort,
    input  logic [NFRAME_WIDTH-1:0]  n_frames,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic [7:0]               t_data,
    input  logic                     fifo_full,
    output logic                     cap_start,
    output logic                     cap_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_lost,
    output logic [NFRAME_WIDTH-1:0]  frame_count
);

    localparam int unsigned BcW = $clog2(FRAME_BYTES);
    localparam logic [BcW-1:0] LastByte = BcW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StSync, StRun, StPause} state_e;

    state_e                   state_q, state_d;
    logic [NFRAME_WIDTH-1:0]  n_frames_q, n_frames_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic [BcW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [NFRAME_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic                     cap_start_q, cap_start_d;
    logic                     cap_enable_q, cap_enable_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_timeout_q, err_timeout_d;
    logic                     err_lost_q, err_lost_d;

    logic [NFRAME_WIDTH-1:0]  frame_inc;
    logic                     last_byte;

    assign frame_inc = frame_count_q + NFRAME_WIDTH'(1);
    assign last_byte = (byte_cnt_q == LastByte);

    always_comb begin
        state_d       = state_q;
        n_frames_d    = n_frames_q;
        timeout_d     = timeout_q;
        to_cnt_d      = to_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        frame_count_d = frame_count_q;
        err_timeout_d = err_timeout_q;
        err_lost_d    = err_lost_q;
        cap_start_d   = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_start && !cmd_abort) begin
                    n_frames_d    = n_frames;
                    timeout_d     = timeout_cycles;
                    err_timeout_d = 1'b0;
                    err_lost_d    = 1'b0;
                    frame_count_d = '0;
                    if (n_frames == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StSync;
                        to_cnt_d = '0;
                    end
                end
            end
            StSync: begin
                if (cmd_abort) begin
                    state_d = StIdle;
                end else if (t_data == HEADER) begin
                    state_d     = StRun;
                    cap_start_d = 1'b1;
                    byte_cnt_d  = BcW'(1);
                end else if (timeout_q != '0 && to_cnt_q + TIMEOUT_WIDTH'(1) == timeout_q) begin
                    state_d       = StIdle;
                    err_timeout_d = 1'b1;
                    done_d        = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            StRun: begin
                if (cmd_abort) begin
                    state_d = StIdle;
                end else begin
                    byte_cnt_d = last_byte ? '0 : byte_cnt_q + BcW'(1);
                    if (last_byte) begin
                        frame_count_d = frame_inc;
                    end
                    // Completion outranks back-pressure, which outranks the header check.
                    if (last_byte && frame_inc == n_frames_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (fifo_full) begin
                        state_d = StPause;
                    end else if (byte_cnt_q == '0 && t_data != HEADER) begin
                        state_d    = StSync;
                        to_cnt_d   = '0;
                        err_lost_d = 1'b1;
                    end
                end
            end
            StPause: begin
                if (cmd_abort) begin
                    state_d = StIdle;
                end else if (!fifo_full) begin
                    state_d  = StSync;
                    to_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        cap_enable_d = (state_d == StRun);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            n_frames_q    <= '0;
            timeout_q     <= '0;
            to_cnt_q      <= '0;
            byte_cnt_q    <= '0;
            frame_count_q <= '0;
            cap_start_q   <= 1'b0;
            cap_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_lost_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_frames_q    <= n_frames_d;
            timeout_q     <= timeout_d;
            to_cnt_q      <= to_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_count_q <= frame_count_d;
            cap_start_q   <= cap_start_d;
            cap_enable_q  <= cap_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_lost_q    <= err_lost_d;
        end
    end

    assign cap_start   = cap_start_q;
    assign cap_enable  = cap_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_lost    = err_lost_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed scenarios with randomized stream contents, header positions and lengths;
// expected event cycles are derived arithmetically from the frame geometry.
module tb_capture_sequencer;

    localparam int         FB    = 48;
    localparam logic [7:0] HDR   = 8'hBC;
    localparam int         NEVER = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst, cmd_start, cmd_abort, fifo_full;
    logic [9:0] n_frames;
    logic [15:0] timeout_cycles;
    logic [7:0] t_data;
    logic       cap_start, cap_enable, busy, done, err_timeout, err_lost;
    logic [9:0] frame_count;

    capture_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .n_frames      (n_frames),
        .timeout_cycles(timeout_cycles),
        .t_data        (t_data),
        .fifo_full     (fifo_full),
        .cap_start     (cap_start),
        .cap_enable    (cap_enable),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .err_lost      (err_lost),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Stream description: aligned headers every FB cycles from hdr_h, optional bad boundary.
    int hdr_h, bad_c, ff_from, ff_to;
    bit mid_hdr;

    // Per-scenario event log.
    int n_cs, n_done, n_en, done_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] filler();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        if (b >= HDR) b = b + 8'd1;
        return b;
    endfunction

    function automatic logic [7:0] stream_byte(input int c);
        logic [7:0] b;
        int pos;
        b = filler();
        if (c >= hdr_h) begin
            pos = (c - hdr_h) % FB;
            if (pos == 0) b = (c == bad_c) ? 8'h00 : HDR;
            else if (pos == 5 && mid_hdr) b = HDR;
        end
        return b;
    endfunction

    // Apply inputs for cycle cyc, clock once, then observe outputs of cycle cyc+1.
    task automatic tick();
        t_data    = stream_byte(cyc);
        fifo_full = (cyc >= ff_from && cyc < ff_to);
        @(posedge clk);
        #1;
        cyc++;
        if (cap_start) n_cs++;
        if (done) begin
            n_done++;
            done_at = cyc;
        end
        if (cap_enable) n_en++;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic new_scenario();
        hdr_h   = NEVER;
        bad_c   = -1;
        ff_from = -1;
        ff_to   = -1;
        mid_hdr = 1'b1;
        n_cs    = 0;
        n_done  = 0;
        n_en    = 0;
        done_at = -1;
    endtask

    task automatic start(input int n, input int to);
        cmd_start      = 1'b1;
        n_frames       = 10'(n);
        timeout_cycles = 16'(to);
        tick();
        cmd_start      = 1'b0;
        n_frames       = 10'($urandom);
        timeout_cycles = 16'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {16'd0, cap_start, cap_enable, busy, done, err_timeout, err_lost, frame_count},
            32'd0);
    endtask

    int n, h, t;

    initial begin
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        n_frames = '0;
        timeout_cycles = '0;
        new_scenario();
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        // Nominal run with a mid-payload header byte and an ignored restart.
        new_scenario();
        n = $urandom_range(2, 4);
        h = cyc + 1 + $urandom_range(8, 20);
        hdr_h = h;
        start(n, 0);
        chk("nom_busy", busy, 1);
        chk("nom_en_sync", cap_enable, 0);
        run_until(cyc + 2);
        cmd_start = 1'b1;
        n_frames  = 10'd7;
        tick();
        cmd_start = 1'b0;
        run_until(h + 1);
        chk("nom_cap_start", cap_start, 1);
        chk("nom_en", cap_enable, 1);
        run_until(h + FB);
        chk("nom_fc1", frame_count, 1);
        run_until(h + FB * n - 1);
        chk("nom_not_done", done, 0);
        chk("nom_fc_pre", frame_count, n - 1);
        run_until(h + FB * n);
        chk("nom_done", done, 1);
        chk("nom_busy_end", busy, 0);
        chk("nom_en_end", cap_enable, 0);
        chk("nom_fc", frame_count, n);
        run_until(cyc + 5);
        chk("nom_cs_count", n_cs, 1);
        chk("nom_done_count", n_done, 1);
        chk("nom_en_cycles", n_en, FB * n - 1);
        chk("nom_errs", {err_timeout, err_lost}, 0);

        // Header-search timeout.
        new_scenario();
        t = $urandom_range(4, 20);
        start(5, t);
        run_until(cyc + t - 1);
        chk("to_busy_pre", busy, 1);
        chk("to_err_pre", err_timeout, 0);
        run_until(cyc + 1);
        chk("to_done", done, 1);
        chk("to_err", err_timeout, 1);
        chk("to_busy", busy, 0);
        run_until(cyc + 3);
        chk("to_no_cs", n_cs, 0);
        chk("to_done_count", n_done, 1);

        // Lost header at the second frame boundary.
        new_scenario();
        mid_hdr = 1'b0;
        h = cyc + 1 + $urandom_range(3, 20);
        hdr_h = h;
        bad_c = h + FB;
        start(3, 0);
        chk("lost_err_to_cleared", err_timeout, 0);
        run_until(h + FB);
        chk("lost_fc_a", frame_count, 1);
        chk("lost_err_pre", err_lost, 0);
        run_until(h + FB + 1);
        chk("lost_err", err_lost, 1);
        chk("lost_en", cap_enable, 0);
        chk("lost_fc_b", frame_count, 1);
        chk("lost_busy", busy, 1);
        run_until(h + 2 * FB + 1);
        chk("lost_resync", cap_start, 1);
        run_until(h + 4 * FB);
        chk("lost_done", done, 1);
        chk("lost_fc", frame_count, 3);
        chk("lost_cs_count", n_cs, 2);

        // FIFO back-pressure mid frame 1.
        new_scenario();
        mid_hdr = 1'b0;
        h = cyc + 1 + $urandom_range(6, 15);
        hdr_h = h;
        ff_from = h + 10;
        ff_to = h + 30;
        start(3, 25);
        run_until(h + 11);
        chk("ff_en_pause", cap_enable, 0);
        chk("ff_busy", busy, 1);
        run_until(h + 25);
        chk("ff_en_mid", cap_enable, 0);
        chk("ff_fc_mid", frame_count, 0);
        run_until(h + FB + 1);
        chk("ff_resync", cap_start, 1);
        chk("ff_fc_partial", frame_count, 0);
        run_until(h + 4 * FB);
        chk("ff_done", done, 1);
        chk("ff_fc", frame_count, 3);
        chk("ff_errs", {err_timeout, err_lost}, 0);

        // Abort in RUN.
        new_scenario();
        h = cyc + 1 + $urandom_range(3, 20);
        hdr_h = h;
        start(3, 0);
        run_until(h + FB + 12);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_en", cap_enable, 0);
        chk("ab_fc", frame_count, 1);
        run_until(cyc + 2 * FB);
        chk("ab_no_done", n_done, 0);

        // Zero-frame request.
        new_scenario();
        start(0, 0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_fc_cleared", frame_count, 0);
        tick();
        chk("z_done_pulse", done, 0);

        // Start and abort together in IDLE.
        new_scenario();
        hdr_h = cyc + 3;
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        n_frames  = 10'd2;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        run_until(cyc + 10);
        chk("sa_busy", busy, 0);
        chk("sa_no_cs", n_cs, 0);

        // Reset mid-run.
        new_scenario();
        h = cyc + 1 + $urandom_range(3, 20);
        hdr_h = h;
        start(2, 0);
        run_until(h + FB + 2);
        chk("rst_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_midrun");

        // FIFO full on the final byte still completes.
        new_scenario();
        h = cyc + 1 + $urandom_range(3, 20);
        hdr_h = h;
        ff_from = h + FB - 1;
        ff_to = h + FB;
        start(1, 0);
        run_until(h + FB);
        chk("fl_done", done, 1);
        chk("fl_fc", frame_count, 1);
        chk("fl_en", cap_enable, 0);
        chk("fl_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
